// File: rtl/ifu_fetch.sv
// Instruction fetch unit: takes one PC at a time from the core, issues one memory
// read, and returns the fetched word to the core. Only one request is outstanding at a time.
//
// state | meaning
// IDLE  | ready for a new PC from the core
// REQ   | read request presented to memory, waiting for acceptance
// WAIT  | request accepted, waiting for the response
// HOLD  | instruction (or fault) offered to the core
// DROP  | flushed while a response is still owed; swallow it
module ifu_fetch #(
    parameter logic [31:0] RESET_IST = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        fetch_ready,
    input  logic        flush,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] ist,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    output logic [31:0] fetch_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ist_q, ist_d;
    logic        fault_q, fault_d;
    logic [31:0] cnt_q, cnt_d;
    logic        kill_q, kill_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ist_d   = ist_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_valid && !flush) begin
                    pc_d = fetch_pc;
                    if (fetch_pc[1:0] == 2'b00) begin
                        state_d = S_REQ;
                        fault_d = 1'b0;
                    end else begin
                        state_d = S_HOLD;
                        ist_d   = RESET_IST;
                        fault_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                // A flush cannot retract the request; remember it and drop the reply later.
                kill_d = kill_q | flush;
                if (mem_req_ready) begin
                    state_d = (kill_q || flush) ? S_DROP : S_WAIT;
                    kill_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = mem_rsp_valid ? S_IDLE : S_DROP;
                end else if (mem_rsp_valid) begin
                    state_d = S_HOLD;
                    ist_d   = mem_rsp_data;
                    fault_d = mem_rsp_err;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (inst_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            S_DROP: begin
                if (mem_rsp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= 32'd0;
            ist_q   <= RESET_IST;
            fault_q <= 1'b0;
            cnt_q   <= 32'd0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ist_q   <= ist_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
        end
    end

    assign fetch_ready   = (state_q == S_IDLE) && !flush;
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = pc_q;
    assign inst_valid    = (state_q == S_HOLD);
    assign ist           = (state_q == S_HOLD) ? ist_q : RESET_IST;
    assign inst_pc       = pc_q;
    assign inst_fault    = (state_q == S_HOLD) && fault_q;
    assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of one in-flight fetch.
module tb_ifu_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid, flush, mem_req_ready, mem_rsp_valid, mem_rsp_err, inst_ready;
    logic [31:0] fetch_pc, mem_rsp_data;
    logic        fetch_ready, mem_req_valid, inst_valid, inst_fault;
    logic [31:0] mem_req_addr, ist, inst_pc, fetch_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ifu_fetch #(.RESET_IST(NOP)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
        .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .ist(ist), .inst_pc(inst_pc),
        .inst_fault(inst_fault), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Model: one fetch transaction and what has happened to it so far.
    bit          m_busy, m_need_req, m_outstanding, m_killed, m_have;
    logic [31:0] m_pc, m_data, m_cnt;
    bit          m_fault;

    task automatic model_reset();
        m_busy = 0; m_need_req = 0; m_outstanding = 0; m_killed = 0; m_have = 0;
        m_pc = 0; m_data = NOP; m_fault = 0; m_cnt = 0;
    endtask

    task automatic model_update();
        if (!reset) begin
            model_reset();
        end else if (!m_busy) begin
            if (fetch_valid && !flush) begin
                m_busy = 1;
                m_pc   = fetch_pc;
                if (fetch_pc % 4 != 0) begin
                    m_have = 1; m_data = NOP; m_fault = 1;
                end else begin
                    m_need_req = 1;
                end
            end
        end else if (m_need_req) begin
            if (flush) m_killed = 1;
            if (mem_req_ready) begin
                m_need_req = 0; m_outstanding = 1;
            end
        end else if (m_outstanding) begin
            if (mem_rsp_valid) begin
                m_outstanding = 0;
                if (m_killed || flush) begin
                    m_busy = 0; m_killed = 0;
                end else begin
                    m_have = 1; m_data = mem_rsp_data; m_fault = mem_rsp_err;
                end
            end else if (flush) begin
                m_killed = 1;
            end
        end else if (m_have) begin
            if (flush || inst_ready) begin
                if (!flush) m_cnt = m_cnt + 1;
                m_busy = 0; m_have = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        if (!reset) model_reset();
        chk("fetch_ready", 32'(fetch_ready), 32'(!m_busy && !flush));
        chk("mem_req_valid", 32'(mem_req_valid), 32'(m_need_req));
        if (m_need_req) chk("mem_req_addr", mem_req_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(m_have));
        chk("ist", ist, m_have ? m_data : NOP);
        if (m_have) begin
            chk("inst_pc", inst_pc, m_pc);
            chk("inst_fault", 32'(inst_fault), 32'(m_fault));
        end
        chk("fetch_cnt", fetch_cnt, m_cnt);
    endtask

    task automatic settle();
        #1;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        fetch_valid = 0; fetch_pc = 0; flush = 0; mem_req_ready = 0;
        mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0; inst_ready = 0;
    endtask

    initial begin
        logic [31:0] pc_r;
        reset = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        settle();
        chk("rst_ist", ist, 32'h00000013);
        chk("rst_fetch_cnt", fetch_cnt, 0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 0);
        chk("rst_mem_req_addr", mem_req_addr, 0);
        tick();
        reset = 1;

        // Normal fetch, zero-wait memory
        fetch_valid = 1; fetch_pc = 32'h80000000; mem_req_ready = 1; inst_ready = 1;
        settle(); chk("nf_fetch_ready", 32'(fetch_ready), 1); tick();
        fetch_valid = 0;
        settle(); chk("nf_req_valid_T1", 32'(mem_req_valid), 1);
        chk("nf_req_addr_T1", mem_req_addr, 32'h80000000); tick();
        mem_rsp_valid = 1; mem_rsp_data = 32'h00100093;
        settle(); chk("nf_inst_valid_T2", 32'(inst_valid), 0); tick();
        mem_rsp_valid = 0;
        settle(); chk("nf_inst_valid_T3", 32'(inst_valid), 1);
        chk("nf_ist", ist, 32'h00100093); chk("nf_inst_pc", inst_pc, 32'h80000000); tick();
        settle(); chk("nf_cnt", fetch_cnt, 1); chk("nf_ist_idle", ist, NOP);

        // Backpressure on both request and instruction channels
        fetch_valid = 1; fetch_pc = 32'h80000010; mem_req_ready = 0; inst_ready = 0;
        settle(); tick();
        fetch_valid = 0;
        for (int i = 0; i < 3; i++) begin
            settle(); chk("bp_req_valid", 32'(mem_req_valid), 1);
            chk("bp_req_addr", mem_req_addr, 32'h80000010); tick();
        end
        mem_req_ready = 1;
        settle(); chk("bp_req_valid_acc", 32'(mem_req_valid), 1); tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE0123;
        settle(); tick();
        mem_rsp_valid = 0; mem_rsp_data = 32'h0;
        for (int i = 0; i < 2; i++) begin
            settle(); chk("bp_hold_ist", ist, 32'hCAFE0123); tick();
        end
        inst_ready = 1;
        settle(); tick();
        settle(); chk("bp_cnt", fetch_cnt, 2);

        // Misaligned PC faults without touching memory
        fetch_valid = 1; fetch_pc = 32'h80000002;
        settle(); tick();
        fetch_valid = 0;
        settle(); chk("mis_inst_valid", 32'(inst_valid), 1); chk("mis_fault", 32'(inst_fault), 1);
        chk("mis_ist", ist, 32'h00000013); chk("mis_req", 32'(mem_req_valid), 0); tick();

        // Flush while waiting for the response
        fetch_valid = 1; fetch_pc = 32'h80000000; mem_req_ready = 1;
        settle(); tick();
        fetch_valid = 0;
        settle(); tick();
        flush = 1;
        settle(); tick();
        flush = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hDEADBEEF;
        settle(); chk("fl_drop_fetch_ready", 32'(fetch_ready), 0); tick();
        mem_rsp_valid = 0;
        settle(); chk("fl_inst_valid", 32'(inst_valid), 0); chk("fl_idle", 32'(fetch_ready), 1);
        fetch_valid = 1; fetch_pc = 32'h80000004;
        settle(); tick();
        fetch_valid = 0;
        settle(); tick();
        mem_rsp_valid = 1; mem_rsp_data = 32'h00200113; mem_rsp_err = 1;
        settle(); tick();
        mem_rsp_valid = 0; mem_rsp_err = 0;
        settle(); chk("fl2_ist", ist, 32'h00200113); chk("fl2_pc", inst_pc, 32'h80000004);
        chk("err_fault", 32'(inst_fault), 1); tick();

        // Counter wrap
        force dut.cnt_q = 32'hFFFFFFFF;
        m_cnt = 32'hFFFFFFFF;
        settle(); tick();
        release dut.cnt_q;
        fetch_valid = 1; fetch_pc = 32'h00000001;
        settle(); tick();
        fetch_valid = 0;
        settle(); chk("wrap_pre", fetch_cnt, 32'hFFFFFFFF); tick();
        settle(); chk("wrap_post", fetch_cnt, 0);

        // Reset asserted mid-WAIT, then a stray late response
        fetch_valid = 1; fetch_pc = 32'h80000020;
        settle(); tick();
        fetch_valid = 0;
        settle(); tick();
        settle();
        #2 reset = 0;
        #1;
        chk("rw_req_valid", 32'(mem_req_valid), 0); chk("rw_req_addr", mem_req_addr, 0);
        chk("rw_inst_valid", 32'(inst_valid), 0); chk("rw_ist", ist, NOP);
        chk("rw_inst_pc", inst_pc, 0); chk("rw_fault", 32'(inst_fault), 0);
        chk("rw_cnt", fetch_cnt, 0);
        model_reset();
        tick();
        reset = 1;
        mem_rsp_valid = 1; mem_rsp_data = 32'h12345678;
        settle(); chk("rw_fetch_ready", 32'(fetch_ready), 1); tick();
        mem_rsp_valid = 0;
        settle(); chk("rw_late_ignored", 32'(inst_valid), 0); tick();

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            fetch_valid   = 1'($urandom_range(0, 1));
            pc_r          = $urandom & 32'hFFFFFFFC;
            if ($urandom_range(0, 7) == 0) pc_r = pc_r | 32'($urandom_range(1, 3));
            fetch_pc      = pc_r;
            flush         = ($urandom_range(0, 15) == 0);
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_rsp_valid = ($urandom_range(0, 9) < 4);
            mem_rsp_data  = $urandom;
            mem_rsp_err   = ($urandom_range(0, 7) == 0);
            inst_ready    = ($urandom_range(0, 9) < 6);
            reset         = ($urandom_range(0, 499) != 0);
            settle();
            tick();
        end
        reset = 1;
        idle_inputs();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_IST, default 32'h00000013, SHALL be the value driven on ist while no valid instruction is held.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, SHALL be the asynchronous, active-low reset (0 = in reset).
REQ-004 Port fetch_valid, input, 1, SHALL mean the core presents a PC to fetch.
REQ-005 Port fetch_pc, input, 32, SHALL be the PC to fetch.
REQ-006 Port fetch_ready, output, 1, SHALL mean the block accepts a PC this cycle.
REQ-007 Port flush, input, 1, SHALL mean the core redirects and any in-flight fetch is discarded.
REQ-008 Ports mem_req_valid (output, 1), mem_req_ready (input, 1) and mem_req_addr (output, 32) SHALL form the memory read-request channel.
REQ-009 Ports mem_rsp_valid (input, 1), mem_rsp_data (input, 32) and mem_rsp_err (input, 1) SHALL form the memory response channel; there is no response backpressure.
REQ-010 Ports inst_valid (output, 1), inst_ready (input, 1), ist (output, 32), inst_pc (output, 32) and inst_fault (output, 1) SHALL form the instruction channel to the core.
REQ-011 Port fetch_cnt, output, 32, SHALL count instructions delivered to the core.

Function
REQ-012 The FSM SHALL have states IDLE, REQ, WAIT, HOLD and DROP, and SHALL allow at most one outstanding memory request.
REQ-013 fetch_ready SHALL be 1 only in IDLE with flush=0.
REQ-014 In IDLE, a cycle with fetch_valid=1 and flush=0 SHALL latch fetch_pc; the next state SHALL be REQ if fetch_pc[1:0]==0, else HOLD with inst_fault=1 and ist=RESET_IST.
REQ-015 In REQ, mem_req_valid SHALL be 1 and mem_req_addr SHALL equal the latched PC, held stable until mem_req_ready=1.
REQ-016 In REQ, when mem_req_ready=1, the next state SHALL be WAIT, or DROP if a flush occurred during REQ (including that cycle); mem_req_valid SHALL never drop before acceptance.
REQ-017 mem_rsp_valid SHALL be ignored outside WAIT and DROP.
REQ-018 In WAIT, mem_rsp_valid=1 SHALL latch ist=mem_rsp_data and inst_fault=mem_rsp_err, and go to HOLD.
REQ-019 In WAIT, if flush=1 and mem_rsp_valid=1 in the same cycle, the response SHALL be discarded and the next state SHALL be IDLE; if flush=1 alone, the next state SHALL be DROP.
REQ-020 In DROP, the block SHALL wait for mem_rsp_valid, discard the response, and go to IDLE.
REQ-021 In HOLD, inst_valid SHALL be 1, with ist, inst_pc and inst_fault stable until inst_ready=1, after which the next state is IDLE.
REQ-022 In HOLD, flush=1 SHALL force IDLE, not deliver the instruction, and leave fetch_cnt unchanged; flush takes priority over inst_ready.
REQ-023 fetch_cnt SHALL increment by 1 on each cycle with inst_valid & inst_ready & ~flush, wrapping from 32'hFFFFFFFF to 0.
REQ-024 Minimum latency, with mem_req_ready=1 in REQ and the response on the next cycle: fetch accepted at cycle T, mem_req_valid at T+1, response at T+2, inst_valid at T+3.
REQ-025 When not in HOLD, inst_valid SHALL be 0 and ist SHALL hold RESET_IST.

Reset
REQ-026 With reset=0 (asynchronous), the block SHALL force the following immediately: state=IDLE, mem_req_valid=0, mem_req_addr=0, inst_valid=0, ist=RESET_IST, inst_pc=0, inst_fault=0, fetch_cnt=0, and the kill flag cleared.
REQ-027 Assertion of reset in any state, including mid-request, SHALL abandon the transaction; the first cycle after release SHALL be IDLE with fetch_ready=1 unless flush=1.

Verification
REQ-028 Normal fetch: fetch_pc=32'h80000000, zero-wait memory returning 32'h00100093 -> mem_req_addr=32'h80000000 at T+1, inst_valid at T+3 with ist=32'h00100093 and inst_pc=32'h80000000, fetch_cnt=1 after the handshake.
REQ-029 Backpressure: mem_req_ready low for 3 cycles, then inst_ready low for 2 cycles -> mem_req_valid and mem_req_addr stable throughout, ist stable in HOLD, a single fetch_cnt increment.
REQ-030 Misaligned: fetch_pc=32'h80000002 -> no memory request, inst_valid at T+1 with inst_fault=1 and ist=32'h00000013.
REQ-031 Flush in WAIT: flush one cycle before the response of 32'hDEADBEEF -> DROP, response discarded, inst_valid never 1, return to IDLE; then a fetch of 32'h80000004 completes normally.
REQ-032 Error and wrap: mem_rsp_err=1 -> inst_fault=1 in HOLD; separately, fetch_cnt preloaded to 32'hFFFFFFFF via 2^32-1 deliveries (or a forced value in the bench) -> 0 after the next delivery.
REQ-033 Reset mid-WAIT: reset=0 while waiting -> outputs at reset values within the same cycle, and a late mem_rsp_valid after release is ignored.
